// File: rtl/text_buf_pkg.sv
// Shared constants, state encoding and word formatting for the text buffer
// write sequencer.
//   BLANK_WORD      : buffer word for an erased cell (space); matches the buffer's reset contents
//   CH_BS / CH_FF   : backspace and form-feed control codes
//   PRINT_LO/HI     : inclusive range of printable ASCII codes
//   tb_state_t      : sequencer states
//   char_word()     : formats a printable code as a buffer word
//   is_printable()  : true for codes in PRINT_LO..PRINT_HI
package text_buf_pkg;

  localparam logic [31:0] BLANK_WORD = 32'h0000_0120;
  localparam logic [7:0]  CH_BS      = 8'h08;
  localparam logic [7:0]  CH_FF      = 8'h0C;
  localparam logic [7:0]  PRINT_LO   = 8'h20;
  localparam logic [7:0]  PRINT_HI   = 8'h7E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } tb_state_t;

  function automatic logic [31:0] char_word(input logic [7:0] code);
    return {23'd0, 1'b1, code};
  endfunction

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= PRINT_LO) && (code <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor register for the text buffer: an ADDR_W-bit up/down counter.
//   clk, rst : clock and synchronous active-high reset (cursor -> 0)
//   inc      : advance; at NUM_REGS-1 wraps to 0 (WRAP=1) or holds (WRAP=0)
//   dec      : step back; holds at 0
//   clr      : force to 0 (highest priority)
//   cursor   : registered cursor position
module text_cursor #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [ADDR_W-1:0] cursor
);

  // Wrap is compared against the last index explicitly so a NUM_REGS that is
  // not a power of two still wraps at the right place.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] cursor_q;
  logic [ADDR_W-1:0] cursor_d;

  always_comb begin
    cursor_d = cursor_q;
    if (clr) begin
      cursor_d = '0;
    end else if (inc) begin
      if (cursor_q == LAST_ADDR) begin
        if (WRAP) cursor_d = '0;
        else      cursor_d = LAST_ADDR;
      end else begin
        cursor_d = cursor_q + ADDR_W'(1);
      end
    end else if (dec) begin
      if (cursor_q != '0) cursor_d = cursor_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cursor_q <= '0;
    else     cursor_q <= cursor_d;
  end

  assign cursor = cursor_q;

endmodule

// File: rtl/text_buf_ctrl.sv
// Write sequencer for the VGA text buffer register file.
// Takes character codes from the keyboard decoder over a valid/ready
// handshake and turns each into a buffer write, a backspace erase or a
// full-buffer clear sweep, while tracking the cursor.
//   clk, rst    : clock, synchronous active-high reset
//   char_valid  : char_code is valid
//   char_code   : ASCII code from the keyboard decoder
//   char_ready  : code can be accepted this cycle
//   clr_req     : single-cycle request to clear the whole buffer
//   wr_addr     : buffer write address
//   wr_en       : buffer write enable
//   en_2        : buffer write qualifier, always equal to wr_en
//   wr_data     : buffer write data
//   cursor      : current cursor position (VGA cursor overlay)
//   busy        : clear sweep in progress
// All outputs come straight from flops; a code accepted at one edge shows
// up on wr_* in the following cycle, together with the updated cursor.
module text_buf_ctrl
  import text_buf_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_code,
  output logic              char_ready,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              en_2,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  tb_state_t         state_q, state_d;
  logic              char_ready_q, char_ready_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic              cur_inc, cur_dec, cur_clr;
  logic              xfer;
  logic              start_clear;

  // A clear request in the same cycle as a valid code wins: the code is not
  // taken, so the source keeps presenting it until the sweep is over.
  assign xfer        = (state_q == IDLE) && char_valid && char_ready_q && !clr_req;
  assign start_clear = (state_q == IDLE) && (clr_req || (xfer && (char_code == CH_FF)));

  text_cursor #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .WRAP     (WRAP)
  ) u_cursor (
    .clk    (clk),
    .rst    (rst),
    .inc    (cur_inc),
    .dec    (cur_dec),
    .clr    (cur_clr),
    .cursor (cursor)
  );

  always_comb begin
    state_d      = state_q;
    char_ready_d = char_ready_q;
    busy_d       = busy_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cur_inc      = 1'b0;
    cur_dec      = 1'b0;
    cur_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        char_ready_d = 1'b1;
        busy_d       = 1'b0;
        if (start_clear) begin
          // First sweep write (address 0) is issued on entry.
          state_d      = CLEAR;
          char_ready_d = 1'b0;
          busy_d       = 1'b1;
          wr_en_d      = 1'b1;
          wr_addr_d    = '0;
          wr_data_d    = BLANK_WORD;
          cur_clr      = 1'b1;
        end else if (xfer) begin
          // Every accepted code spends one cycle in WRITE, even when dropped.
          state_d      = WRITE;
          char_ready_d = 1'b0;
          if (is_printable(char_code)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor;
            wr_data_d = char_word(char_code);
            cur_inc   = 1'b1;
          end else if (char_code == CH_BS) begin
            wr_en_d   = 1'b1;
            wr_addr_d = (cursor == '0) ? '0 : cursor - ADDR_W'(1);
            wr_data_d = BLANK_WORD;
            cur_dec   = 1'b1;
          end
        end
      end

      WRITE: begin
        state_d      = IDLE;
        char_ready_d = 1'b1;
      end

      CLEAR: begin
        // wr_addr_q doubles as the sweep address counter.
        if (wr_addr_q == LAST_ADDR) begin
          state_d      = IDLE;
          char_ready_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          wr_data_d = BLANK_WORD;
        end
      end

      default: begin
        state_d      = IDLE;
        char_ready_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      char_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= BLANK_WORD;
    end else begin
      state_q      <= state_d;
      char_ready_q <= char_ready_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign char_ready = char_ready_q;
  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign en_2       = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Bench for text_buf_ctrl: two instances (wrapping and saturating cursor)
// share one stimulus stream; a queue-based model of the buffer writes and
// cursor is compared against what each instance writes.
module tb_text_buf_ctrl;

  localparam int          N     = 16;
  localparam logic [31:0] BLANK = 32'h0000_0120;

  logic       clk = 1'b0;
  logic       rst;
  logic       char_valid;
  logic [7:0] char_code;
  logic       clr_req;

  logic        rdy_w, we_w, e2_w, busy_w;
  logic [3:0]  wa_w, cur_w;
  logic [31:0] wd_w;
  logic        rdy_s, we_s, e2_s, busy_s;
  logic [3:0]  wa_s, cur_s;
  logic [31:0] wd_s;

  text_buf_ctrl #(.NUM_REGS(N), .ADDR_W(4), .WRAP(1'b1)) u_dut_wrap (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .char_ready(rdy_w), .clr_req(clr_req), .wr_addr(wa_w), .wr_en(we_w),
    .en_2(e2_w), .wr_data(wd_w), .cursor(cur_w), .busy(busy_w)
  );

  text_buf_ctrl #(.NUM_REGS(N), .ADDR_W(4), .WRAP(1'b0)) u_dut_sat (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .char_ready(rdy_s), .clr_req(clr_req), .wr_addr(wa_s), .wr_en(we_s),
    .en_2(e2_s), .wr_data(wd_s), .cursor(cur_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfer_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed and expected write streams, {addr, data}.
  logic [35:0] act_w[$];
  logic [35:0] act_s[$];
  logic [35:0] exp_w[$];
  logic [35:0] exp_s[$];
  int mcur_w = 0;
  int mcur_s = 0;

  always @(negedge clk) begin
    if (we_w === 1'b1) act_w.push_back({wa_w, wd_w});
    if (we_s === 1'b1) act_s.push_back({wa_s, wd_s});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      exp_w.push_back({4'(i), BLANK});
      exp_s.push_back({4'(i), BLANK});
    end
    mcur_w = 0;
    mcur_s = 0;
  endtask

  task automatic model_code(input logic [7:0] c);
    logic [31:0] w;
    w = 32'h100 + 32'(c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_w.push_back({4'(mcur_w), w});
      exp_s.push_back({4'(mcur_s), w});
      mcur_w = (mcur_w + 1) % N;
      mcur_s = (mcur_s == N - 1) ? N - 1 : mcur_s + 1;
    end else if (c == 8'h08) begin
      if (mcur_w > 0) mcur_w--;
      if (mcur_s > 0) mcur_s--;
      exp_w.push_back({4'(mcur_w), BLANK});
      exp_s.push_back({4'(mcur_s), BLANK});
    end else if (c == 8'h0C) begin
      model_clear();
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (rdy_w !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_code(input logic [7:0] c);
    logic exp_we;
    @(negedge clk);
    wait_ready();
    char_valid = 1'b1;
    char_code  = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    xfer_cyc   = cyc;
    model_code(c);
    exp_we = (c >= 8'h20 && c <= 8'h7E) || (c == 8'h08) || (c == 8'h0C);
    check("cursor_wrap", 64'(cur_w), 64'(mcur_w));
    check("cursor_sat", 64'(cur_s), 64'(mcur_s));
    check("ready_after_xfer", 64'(rdy_w), 64'd0);
    check("wr_en", 64'(we_w), 64'(exp_we));
    check("en_2", 64'(e2_w), 64'(exp_we));
    check("busy_after_xfer", 64'(busy_w), 64'(c == 8'h0C));
  endtask

  task automatic do_clear();
    @(negedge clk);
    wait_ready();
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    model_clear();
    check("clr_cursor", 64'(cur_w), 64'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("clr_busy", 64'(busy_w), 64'd1);
      check("clr_ready", 64'(rdy_w), 64'd0);
      check("clr_addr", 64'(wa_s), 64'(i));
    end
    @(negedge clk);
    check("clr_end_busy", 64'(busy_w), 64'd0);
    check("clr_end_ready", 64'(rdy_w), 64'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    wait_ready();
    @(negedge clk);
    while (exp_w.size() > 0 && act_w.size() > 0)
      check("write_wrap", 64'(act_w.pop_front()), 64'(exp_w.pop_front()));
    check("write_count_wrap", 64'(act_w.size()), 64'(exp_w.size()));
    while (exp_s.size() > 0 && act_s.size() > 0)
      check("write_sat", 64'(act_s.pop_front()), 64'(exp_s.pop_front()));
    check("write_count_sat", 64'(act_s.size()), 64'(exp_s.size()));
    act_w.delete(); exp_w.delete();
    act_s.delete(); exp_s.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(we_w), 64'd0);
    check({tag, "_en_2"}, 64'(e2_w), 64'd0);
    check({tag, "_wr_addr"}, 64'(wa_w), 64'd0);
    check({tag, "_wr_data"}, 64'(wd_w), 64'(BLANK));
    check({tag, "_ready"}, 64'(rdy_w), 64'd0);
    check({tag, "_busy"}, 64'(busy_w), 64'd0);
    check({tag, "_cursor"}, 64'(cur_w), 64'd0);
  endtask

  logic [7:0] other_codes [8] = '{8'h00, 8'h01, 8'h0A, 8'h0D, 8'h1B, 8'h7F, 8'h80, 8'hFF};

  initial begin
    int t0;
    int r;
    int n;
    rst        = 1'b1;
    char_valid = 1'b0;
    char_code  = 8'h00;
    clr_req    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("ready_still_low", 64'(rdy_w), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(rdy_w), 64'd1);

    // 'A','B' back to back: one code every two cycles.
    send_code(8'h41);
    t0 = xfer_cyc;
    check("wr_A", 64'({wa_w, wd_w}), 64'({4'd0, 32'h141}));
    send_code(8'h42);
    check("wr_B", 64'({wa_w, wd_w}), 64'({4'd1, 32'h142}));
    check("throughput", 64'(xfer_cyc - t0), 64'd2);
    drain();

    // Fill to 16 codes, then one more: wrap vs saturate.
    for (int i = 0; i < 14; i++) send_code(8'h43 + 8'(i));
    check("wrap_cursor16", 64'(cur_w), 64'd0);
    check("sat_cursor16", 64'(cur_s), 64'd15);
    send_code(8'h51);
    check("sat_overwrite15", 64'(wa_s), 64'd15);
    drain();

    // Backspace at cursor 3, then at cursor 0 after a clear.
    send_code(8'h52);
    send_code(8'h53);
    check("bs_pre_cursor", 64'(cur_w), 64'd3);
    send_code(8'h08);
    check("bs_write", 64'({wa_w, wd_w}), 64'({4'd2, 32'h120}));
    do_clear();
    send_code(8'h08);
    check("bs_at0_write", 64'({wa_w, wd_w}), 64'({4'd0, 32'h120}));
    drain();

    // Clear and 'Z' presented together: clear first, 'Z' held and then written.
    @(negedge clk);
    wait_ready();
    clr_req    = 1'b1;
    char_valid = 1'b1;
    char_code  = 8'h5A;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    model_clear();
    check("clr_vs_char_ready", 64'(rdy_w), 64'd0);
    check("clr_vs_char_busy", 64'(busy_w), 64'd1);
    n = 0;
    @(negedge clk);
    while (rdy_w !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("held_char_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    model_code(8'h5A);
    check("held_Z_write", 64'({we_w, wa_w, wd_w}), 64'({1'b1, 4'd0, 32'h15A}));
    check("held_Z_cursor", 64'(cur_w), 64'd1);
    send_code(8'h01);
    drain();

    // Randomised mix of codes and clears.
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      send_code(8'($urandom_range(32, 126)));
      else if (r < 82) send_code(8'h08);
      else if (r < 85) send_code(8'h0C);
      else if (r < 92) send_code(other_codes[$urandom_range(0, 7)]);
      else             do_clear();
      if (it % 20 == 19) drain();
    end
    drain();

    // Reset during clear cycle 5: only addresses 0..4 get written.
    @(negedge clk);
    wait_ready();
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_w.push_back({4'(i), BLANK});
      exp_s.push_back({4'(i), BLANK});
    end
    mcur_w = 0;
    mcur_s = 0;
    check_reset_outputs("midclr");
    @(negedge clk);
    check("midclr_no_write", 64'(we_w), 64'd0);
    @(posedge clk);
    #1;
    check("midclr_ready_back", 64'(rdy_w), 64'd1);
    drain();
    send_code(8'h58);
    check("post_rst_write", 64'({wa_w, wd_w}), 64'({4'd0, 32'h158}));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
